// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV64 main controller.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_t;

  typedef enum logic [2:0] {
    ClsR,
    ClsI,
    ClsLoad,
    ClsStore,
    ClsIll
  } ins_cls_t;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  localparam int unsigned AluCcW = 4;
  localparam logic [AluCcW-1:0] AluAnd = 4'b0000;
  localparam logic [AluCcW-1:0] AluOr  = 4'b0001;
  localparam logic [AluCcW-1:0] AluAdd = 4'b0010;
  localparam logic [AluCcW-1:0] AluSub = 4'b0110;
  localparam logic [AluCcW-1:0] AluSlt = 4'b0111;

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseImemTo  = 2'b10;
  localparam logic [1:0] CauseDmemTo  = 2'b11;

  function automatic ins_cls_t classify(input logic [6:0] op);
    ins_cls_t cls;
    case (op)
      OpR:     cls = ClsR;
      OpI:     cls = ClsI;
      OpLoad:  cls = ClsLoad;
      OpStore: cls = ClsStore;
      default: cls = ClsIll;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from {opcode, funct3, funct7}; memory ops force ADD.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  output logic [AluCcW-1:0] alu_cc_o
);

  always_comb begin
    alu_cc_o = AluAdd;
    if (opcode_i == OpR || opcode_i == OpI) begin
      case (funct3_i)
        // funct7 only selects SUB for register-register ops; for I-type it is immediate bits.
        3'b000:  alu_cc_o = (opcode_i == OpR && funct7_i == 7'b0100000) ? AluSub : AluAdd;
        3'b111:  alu_cc_o = AluAnd;
        3'b110:  alu_cc_o = AluOr;
        3'b010:  alu_cc_o = AluSlt;
        default: alu_cc_o = AluAdd;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle fetch/decode/exec/mem/wb controller with req/ack memories and sticky traps.
// Define MC_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters.
module mc_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned INS_W       = 32,
  parameter int unsigned ALU_CC_W    = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INS_W-1:0]    instr,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                ir_load,
  output logic                pc_en,
  output logic                RegWrite,
  output logic                MemtoReg,
  output logic                ALUsrc,
  output logic                MemWrite,
  output logic                MemRead,
  output logic [ALU_CC_W-1:0] ALU_CC,
`ifdef MC_PERF_CNT_EN
  output logic [63:0]         cycle_cnt,
  output logic [63:0]         instret_cnt,
`endif
  output logic                trap,
  output logic [1:0]          trap_cause
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  state_t            state_q, state_d;
  ins_cls_t          cls_q, cls_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [1:0]        cause_q, cause_d;
  logic [6:0]        op_q, f7_q;
  logic [2:0]        f3_q;
  logic [AluCcW-1:0] dec_cc, alu_cc_q, alu_cc_d;
  logic imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, pc_wb_q, pc_wb_d;
  logic reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d, alusrc_q, alusrc_d;
  logic mem_write_q, mem_write_d, mem_read_q, mem_read_d, trap_q;
  logic mem_pc_en;
  logic unused_instr;

  assign unused_instr = ^{instr[24:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .opcode_i (op_q),
    .funct3_i (f3_q),
    .funct7_i (f7_q),
    .alu_cc_o (dec_cc)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    cnt_inc   = cnt_q + CntW'(1);
    ir_load   = 1'b0;
    mem_pc_en = 1'b0;
    unique case (state_q)
      StFetch: begin
        // The first cycle after reset has no request outstanding, so it is not a wait cycle.
        if (imem_req_q) begin
          if (imem_ack) begin
            ir_load = 1'b1;
            state_d = StDecode;
          end else if (cnt_inc == CntW'(TIMEOUT_CYC)) begin
            state_d = StTrap;
            cause_d = CauseImemTo;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StDecode: begin
        cls_d = classify(op_q);
        if (cls_d == ClsIll) begin
          state_d = StTrap;
          cause_d = CauseIllegal;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = (cls_q == ClsLoad || cls_q == ClsStore) ? StMem : StWb;
        cnt_d   = '0;
      end
      StMem: begin
        if (dmem_ack) begin
          if (cls_q == ClsStore) begin
            mem_pc_en = 1'b1;
            state_d   = StFetch;
            cnt_d     = '0;
          end else begin
            state_d = StWb;
          end
        end else if (cnt_inc == CntW'(TIMEOUT_CYC)) begin
          state_d = StTrap;
          cause_d = CauseDmemTo;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWb: begin
        state_d = StFetch;
        cnt_d   = '0;
      end
      StTrap: ;
      default: state_d = StTrap;
    endcase

    // Strobes are registered, so they are decoded from the state being entered.
    imem_req_d   = 1'b0;
    dmem_req_d   = 1'b0;
    pc_wb_d      = 1'b0;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    alusrc_d     = 1'b0;
    mem_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    alu_cc_d     = '0;
    unique case (state_d)
      StFetch: imem_req_d = 1'b1;
      StExec: begin
        alusrc_d = (cls_d != ClsR);
        alu_cc_d = dec_cc;
      end
      StMem: begin
        dmem_req_d  = 1'b1;
        mem_read_d  = (cls_d == ClsLoad);
        mem_write_d = (cls_d == ClsStore);
        alusrc_d    = 1'b1;
        alu_cc_d    = dec_cc;
      end
      StWb: begin
        reg_write_d  = 1'b1;
        pc_wb_d      = 1'b1;
        mem_to_reg_d = (cls_d == ClsLoad);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFetch;
      cls_q        <= ClsR;
      cnt_q        <= '0;
      cause_q      <= CauseNone;
      op_q         <= '0;
      f3_q         <= '0;
      f7_q         <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      pc_wb_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alusrc_q     <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      alu_cc_q     <= '0;
      trap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      cnt_q        <= cnt_d;
      cause_q      <= cause_d;
      if (ir_load) begin
        op_q <= instr[6:0];
        f3_q <= instr[14:12];
        f7_q <= instr[31:25];
      end
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      pc_wb_q      <= pc_wb_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alusrc_q     <= alusrc_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      alu_cc_q     <= alu_cc_d;
      trap_q       <= (state_d == StTrap);
    end
  end

  assign imem_req   = imem_req_q;
  assign dmem_req   = dmem_req_q;
  assign pc_en      = pc_wb_q | mem_pc_en;
  assign RegWrite   = reg_write_q;
  assign MemtoReg   = mem_to_reg_q;
  assign ALUsrc     = alusrc_q;
  assign MemWrite   = mem_write_q;
  assign MemRead    = mem_read_q;
  assign ALU_CC     = ALU_CC_W'(alu_cc_q);
  assign trap       = trap_q;
  assign trap_cause = cause_q;

`ifdef MC_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_q + 64'd1;
      instret_cnt_q <= instret_cnt_q + {63'd0, pc_en};
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule
